// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time. Aligns addresses and steers byte lanes, then sign- or zero-extends load data.
// Faulting requests respond one cycle after accept. Legal requests hold the memory strobes until mem_resp.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_store,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_fault,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    store_q, store_d;
    logic                    unsigned_q, unsigned_d;
    logic [1:0]              size_q, size_d;
    logic [OFFW-1:0]         offset_q, offset_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NB-1:0]           be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    fault_q, fault_d;

    logic [OFFW-1:0]         req_offset;
    int                      req_bytes;
    logic                    req_fault;
    logic [NB-1:0]           req_be;
    logic [DATA_WIDTH-1:0]   req_wmask;
    logic [DATA_WIDTH-1:0]   ld_shift;
    logic [DATA_WIDTH-1:0]   ld_ext;
    logic                    ld_sign;

    assign req_offset = req_addr[OFFW-1:0];

    always_comb begin
        req_bytes = 1 << req_funct3[1:0];
        // LWU exists only on the 64-bit bus; stores have no extension variant.
        req_fault = (req_bytes > NB) || (req_funct3 == 3'b111)
                 || (req_store && req_funct3[2])
                 || ((DATA_WIDTH == 32) && (req_funct3 == 3'b110))
                 || ((req_offset & OFFW'(req_bytes - 1)) != '0);
        req_be    = '0;
        req_wmask = '0;
        for (int i = 0; i < NB; i++) begin
            req_be[i]          = (i < req_bytes);
            req_wmask[8*i +: 8] = {8{i < req_bytes}};
        end
    end

    always_comb begin
        ld_shift = mem_rdata >> {offset_q, 3'b000};
        case (size_q)
            2'd0:    ld_sign = ld_shift[7];
            2'd1:    ld_sign = ld_shift[15];
            2'd2:    ld_sign = ld_shift[31];
            default: ld_sign = ld_shift[DATA_WIDTH-1];
        endcase
        ld_sign = ld_sign & ~unsigned_q;
        ld_ext  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ld_ext[i] = (i < (8 << size_q)) ? ld_shift[i] : ld_sign;
        end
    end

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        unsigned_d = unsigned_q;
        size_d     = size_q;
        offset_d   = offset_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    store_d    = req_store;
                    unsigned_d = req_funct3[2];
                    size_d     = req_funct3[1:0];
                    offset_d   = req_offset;
                    addr_d     = {req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                    be_d       = req_be << req_offset;
                    wdata_d    = (req_wdata & req_wmask) << {req_offset, 3'b000};
                    rdata_d    = '0;
                    fault_d    = req_fault;
                    state_d    = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_read  = ~store_q;
                mem_write = store_q;
                if (mem_resp) begin
                    rdata_d = store_q ? '0 : ld_ext;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= '0;
            offset_q   <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            unsigned_q <= unsigned_d;
            size_q     <= size_d;
            offset_q   <= offset_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
        end
    end

    assign mem_address     = addr_q;
    assign mem_byte_enable = be_q;
    assign mem_wdata       = wdata_q;
    assign resp_rdata      = rdata_q;
    assign resp_fault      = fault_q & (state_q == RESP);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-bit instance and a 64-bit instance share clock, reset and request fields.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [63:0] mem_rdata = '0;
    logic        v32 = 1'b0, v64 = 1'b0, r32 = 1'b0, r64 = 1'b0;

    logic        rdy32, rv32, flt32, rd32, wr32;
    logic [31:0] rdat32, addr32, wdat32;
    logic [3:0]  be32;
    logic        rdy64, rv64, flt64, rd64, wr64;
    logic [63:0] rdat64, wdat64;
    logic [31:0] addr64;
    logic [7:0]  be64;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(rv32), .resp_rdata(rdat32),
        .resp_fault(flt32), .mem_address(addr32), .mem_read(rd32), .mem_write(wr32),
        .mem_byte_enable(be32), .mem_wdata(wdat32), .mem_rdata(mem_rdata[31:0]),
        .mem_resp(r32)
    );

    load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u64 (
        .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rdy64),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv64), .resp_rdata(rdat64),
        .resp_fault(flt64), .mem_address(addr64), .mem_read(rd64), .mem_write(wr64),
        .mem_byte_enable(be64), .mem_wdata(wdat64), .mem_rdata(mem_rdata),
        .mem_resp(r64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit wide, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [63:0] wd);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        if (wide) v64 = 1'b1; else v32 = 1'b1;
        tick();
        v32 = 1'b0;
        v64 = 1'b0;
    endtask

    task automatic respond(input bit wide, input logic [63:0] rd);
        mem_rdata = rd;
        if (wide) r64 = 1'b1; else r32 = 1'b1;
        tick();
        r32 = 1'b0;
        r64 = 1'b0;
    endtask

    logic [3:0] fault_vec [4];

    initial begin
        #1 rst = 1'b1;
        #10;
        chk("rst_ready", rdy32, 1);
        chk("rst_resp_valid", rv32, 0);
        chk("rst_fault", flt32, 0);
        chk("rst_strobes", {rd32, wr32}, 0);
        chk("rst_addr", addr32, 0);
        chk("rst_be", be32, 0);
        chk("rst_wdata", wdat32, 0);
        chk("rst_rdata", rdat32, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // LB from the top byte lane, negative value
        issue(0, 0, 3'b000, 32'h1003, 0);
        chk("lb_read", rd32, 1);
        chk("lb_write", wr32, 0);
        chk("lb_addr", addr32, 32'h1000);
        chk("lb_be", be32, 4'b1000);
        chk("lb_ready_busy", rdy32, 0);
        respond(0, 64'h80FF_1234);
        chk("lb_resp_valid", rv32, 1);
        chk("lb_rdata", rdat32, 32'hFFFF_FF80);
        chk("lb_fault", flt32, 0);
        chk("lb_read_done", rd32, 0);
        tick();
        chk("lb_resp_once", rv32, 0);
        chk("lb_ready_again", rdy32, 1);

        // SH upper half
        issue(0, 1, 3'b001, 32'h2002, 64'h1234_ABCD);
        chk("sh_write", wr32, 1);
        chk("sh_read", rd32, 0);
        chk("sh_addr", addr32, 32'h2000);
        chk("sh_wdata", wdat32, 32'hABCD_0000);
        chk("sh_be", be32, 4'b1100);
        respond(0, 64'hDEAD_BEEF);
        chk("sh_resp_valid", rv32, 1);
        chk("sh_rdata", rdat32, 0);
        chk("sh_fault", flt32, 0);
        tick();

        // SB lane 1: upper bits of the store data must be masked off
        issue(0, 1, 3'b000, 32'h0701, 64'hFFFF_FF5A);
        chk("sb_wdata", wdat32, 32'h0000_5A00);
        chk("sb_be", be32, 4'b0010);
        respond(0, 0);
        tick();

        // Misaligned LW
        issue(0, 0, 3'b010, 32'h3001, 0);
        chk("lw_mis_valid", rv32, 1);
        chk("lw_mis_fault", flt32, 1);
        chk("lw_mis_read", rd32, 0);
        chk("lw_mis_rdata", rdat32, 0);
        tick();
        chk("lw_mis_once", rv32, 0);
        chk("lw_mis_fault_clr", flt32, 0);

        // Unsupported encodings on the 32-bit bus: LD, LWU, funct3 111, store with funct3[2]
        fault_vec = '{4'b0_011, 4'b0_110, 4'b0_111, 4'b1_100};
        for (int k = 0; k < 4; k++) begin
            issue(0, fault_vec[k][3], fault_vec[k][2:0], 32'h0, 64'h55);
            chk("enc_fault", flt32, 1);
            chk("enc_valid", rv32, 1);
            chk("enc_strobes", {rd32, wr32}, 0);
            tick();
        end

        // mem_resp in IDLE is ignored
        r32 = 1'b1;
        tick();
        r32 = 1'b0;
        chk("idle_resp_ignored", rv32, 0);
        chk("idle_ready", rdy32, 1);

        // LHU with a slow memory; a competing request during ACCESS must be ignored
        issue(0, 0, 3'b101, 32'h4000, 0);
        v32 = 1'b1;
        req_store = 1'b1;
        req_addr = 32'h5554;
        for (int c = 0; c < 5; c++) begin
            chk("lhu_hold_read", rd32, 1);
            chk("lhu_hold_write", wr32, 0);
            chk("lhu_hold_addr", addr32, 32'h4000);
            chk("lhu_hold_be", be32, 4'b0011);
            chk("lhu_no_resp", rv32, 0);
            tick();
        end
        v32 = 1'b0;
        respond(0, 64'h0000_8001);
        chk("lhu_resp_valid", rv32, 1);
        chk("lhu_rdata", rdat32, 32'h0000_8001);
        tick();
        chk("lhu_resp_once", rv32, 0);

        // Reset while ACCESS is pending
        issue(0, 0, 3'b010, 32'h6000, 0);
        chk("abort_read_pre", rd32, 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_read_drop", rd32, 0);
        chk("abort_ready", rdy32, 1);
        #2 rst = 1'b0;
        respond(0, 64'h1111_2222);
        chk("abort_no_resp", rv32, 0);
        tick();
        chk("abort_no_resp2", rv32, 0);
        chk("abort_ready2", rdy32, 1);

        // 64-bit bus
        issue(1, 0, 3'b010, 32'h14, 0);
        chk("w_lw_be", be64, 8'hF0);
        chk("w_lw_addr", addr64, 32'h10);
        respond(1, 64'h8000_0001_0000_0000);
        chk("w_lw_rdata", rdat64, 64'hFFFF_FFFF_8000_0001);
        tick();

        issue(1, 0, 3'b110, 32'h14, 0);
        chk("w_lwu_fault", flt64, 0);
        respond(1, 64'h8000_0001_0000_0000);
        chk("w_lwu_rdata", rdat64, 64'h0000_0000_8000_0001);
        tick();

        issue(1, 0, 3'b011, 32'h10, 0);
        chk("w_ld_read", rd64, 1);
        chk("w_ld_be", be64, 8'hFF);
        respond(1, 64'h0123_4567_89AB_CDEF);
        chk("w_ld_fault", flt64, 0);
        chk("w_ld_rdata", rdat64, 64'h0123_4567_89AB_CDEF);
        tick();

        issue(1, 0, 3'b011, 32'h14, 0);
        chk("w_ld_mis_fault", flt64, 1);
        chk("w_ld_mis_read", rd64, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
